// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
//   icachef_t      : view of a fetch byte address {tag, idx, bytoff}
//   icache_frame_t : contents of one cache frame {valid, tag, data}
//   icstate_t      : controller states
// The struct widths follow the default geometry (SETS_DEFAULT frames).
package icache_pkg;

  localparam int SETS_DEFAULT  = 16;
  localparam int IDX_W_DEFAULT = $clog2(SETS_DEFAULT);
  localparam int TAG_W_DEFAULT = 30 - IDX_W_DEFAULT;

  typedef struct packed {
    logic [TAG_W_DEFAULT-1:0] tag;
    logic [IDX_W_DEFAULT-1:0] idx;
    logic [1:0]               bytoff;
  } icachef_t;

  typedef struct packed {
    logic                     valid;
    logic [TAG_W_DEFAULT-1:0] tag;
    logic [31:0]              data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icstate_t;

endpackage

// File: rtl/icache_frame_array.sv
// Frame storage for the direct-mapped instruction cache.
//   clk, rst_n : clock, asynchronous active-low reset (clears valid bits only)
//   clr_valid  : synchronous clear of every valid bit
//   wr_en      : write frame wr_idx with {wr_valid, wr_tag, wr_data}
//   rd_idx     : combinational read port -> rd_valid, rd_tag, rd_data
// A write in the same cycle as clr_valid still lands; its own valid bit is
// whatever wr_valid says, so the caller decides which one wins.
module icache_frame_array #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_valid,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data
);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags  [SETS];
  logic [31:0]      words [SETS];

  // NOTE: non-blocking assignments; the later wr_en assignment overrides the
  // clear-all for its own frame because the last scheduled update wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      if (clr_valid) valid <= '0;
      if (wr_en)     valid[wr_idx] <= wr_valid;
    end
  end

  // NOTE: tag/data storage has no reset; the valid bits alone make stale
  // contents invisible, and leaving the arrays unreset lets them map to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx]  <= wr_tag;
      words[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = words[rd_idx];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache.
//   CLK, nRST                : clock, asynchronous active-low reset
//   dp_imemREN, dp_imemaddr  : datapath fetch request (addr[1:0] ignored)
//   dp_ihit, dp_imemload     : same-cycle hit and instruction (0 on no hit)
//   inval                    : synchronous invalidate-all
//   mem_iREN, mem_iaddr      : single-word fill request to memory controller
//   mem_iwait, mem_iload     : memory busy flag / fill data (valid when !iwait)
// A miss latches its word address and holds it through FETCH, so a redirect
// or stall on the fetch side never disturbs an in-flight fill.
module icache_dm
  import icache_pkg::*;
#(
  parameter int SETS = SETS_DEFAULT
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dp_imemREN,
  input  logic [31:0] dp_imemaddr,
  output logic        dp_ihit,
  output logic [31:0] dp_imemload,
  input  logic        inval,
  output logic        mem_iREN,
  output logic [31:0] mem_iaddr,
  input  logic        mem_iwait,
  input  logic [31:0] mem_iload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icstate_t    state, state_next;
  logic [31:0] miss_addr, miss_addr_next;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             hit;
  logic             fill_en;
  logic             unused_bytoff;

  assign req_idx       = dp_imemaddr[IDX_W+1:2];
  assign req_tag       = dp_imemaddr[31:IDX_W+2];
  assign unused_bytoff = ^dp_imemaddr[1:0];

  assign hit = dp_imemREN & rd_valid & (rd_tag == req_tag);

  icache_frame_array #(
    .SETS (SETS),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_frames (
    .clk      (CLK),
    .rst_n    (nRST),
    .clr_valid(inval),
    .wr_en    (fill_en),
    .wr_idx   (miss_addr[IDX_W+1:2]),
    .wr_valid (~inval),  // invalidate coinciding with a fill leaves it invalid
    .wr_tag   (miss_addr[31:IDX_W+2]),
    .wr_data  (mem_iload),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
    end else begin
      state     <= state_next;
      miss_addr <= miss_addr_next;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next     = state;
    miss_addr_next = miss_addr;
    dp_ihit        = 1'b0;
    dp_imemload    = '0;
    mem_iREN       = 1'b0;
    fill_en        = 1'b0;
    case (state)
      IDLE: begin
        if (hit && !inval) begin
          dp_ihit     = 1'b1;
          dp_imemload = rd_data;
        end else if (dp_imemREN && !inval) begin
          state_next     = FETCH;
          miss_addr_next = {dp_imemaddr[31:2], 2'b00};
        end
      end
      FETCH: begin
        mem_iREN = 1'b1;
        if (!mem_iwait) begin
          fill_en    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_iaddr = miss_addr;

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm. Inputs change 1 time unit
// after the rising edge; outputs are sampled 1 unit after that.
module tb_icache_dm;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dp_imemREN;
  logic [31:0] dp_imemaddr;
  logic        dp_ihit;
  logic [31:0] dp_imemload;
  logic        inval;
  logic        mem_iREN;
  logic [31:0] mem_iaddr;
  logic        mem_iwait;
  logic [31:0] mem_iload;

  int checks   = 0;
  int failures = 0;

  icache_dm dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .dp_imemREN (dp_imemREN),
    .dp_imemaddr(dp_imemaddr),
    .dp_ihit    (dp_ihit),
    .dp_imemload(dp_imemload),
    .inval      (inval),
    .mem_iREN   (mem_iREN),
    .mem_iaddr  (mem_iaddr),
    .mem_iwait  (mem_iwait),
    .mem_iload  (mem_iload)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present addr, expect a miss, then serve the fill after `waits` busy cycles
  // and expect the hit on the cycle after the fill.
  task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] data, input int waits);
    dp_imemREN  = 1'b1;
    dp_imemaddr = addr;
    mem_iwait   = 1'b1;
    #1;
    check("miss_ihit", dp_ihit, 0);
    check("miss_iren", mem_iREN, 0);
    tick();
    for (int w = 0; w <= waits; w++) begin
      mem_iwait = (w == waits) ? 1'b0 : 1'b1;
      mem_iload = (w == waits) ? data : 32'hDEAD_BEEF;
      #1;
      check("fetch_iren", mem_iREN, 1);
      check("fetch_iaddr", mem_iaddr, {addr[31:2], 2'b00});
      check("fetch_ihit", dp_ihit, 0);
      tick();
    end
    mem_iwait = 1'b1;
    #1;
    check("fill_ihit", dp_ihit, 1);
    check("fill_load", dp_imemload, data);
    check("fill_iren", mem_iREN, 0);
  endtask

  task automatic expect_hit(input logic [31:0] addr, input logic [31:0] data);
    dp_imemREN  = 1'b1;
    dp_imemaddr = addr;
    #1;
    check("hit_ihit", dp_ihit, 1);
    check("hit_load", dp_imemload, data);
  endtask

  initial begin
    nRST        = 1'b0;
    dp_imemREN  = 1'b0;
    dp_imemaddr = '0;
    inval       = 1'b0;
    mem_iwait   = 1'b1;
    mem_iload   = '0;
    tick();
    tick();
    check("rst_ihit", dp_ihit, 0);
    check("rst_load", dp_imemload, 0);
    check("rst_iren", mem_iREN, 0);
    check("rst_iaddr", mem_iaddr, 0);
    nRST = 1'b1;
    tick();

    // REN=0 with a toggling address: nothing happens
    for (int i = 0; i < 4; i++) begin
      dp_imemaddr = 32'h40 << i;
      #1;
      check("idle_ihit", dp_ihit, 0);
      check("idle_load", dp_imemload, 0);
      tick();
      check("idle_iren", mem_iREN, 0);
    end

    // Cold miss with three wait cycles, then zero-latency repeat and alias
    fetch_miss(32'h40, 32'h8C22_0004, 3);
    tick();
    expect_hit(32'h40, 32'h8C22_0004);
    expect_hit(32'h43, 32'h8C22_0004);

    // Conflict at idx 0: 0x80 evicts 0x40, then 0x40 misses again
    fetch_miss(32'h80, 32'h1111_0080, 0);
    fetch_miss(32'h40, 32'h8C22_0004, 1);

    // Redirect mid-fill: the address stays on the original miss
    dp_imemaddr = 32'h100;
    #1;
    check("redir_miss", dp_ihit, 0);
    tick();
    dp_imemaddr = 32'h200;
    #1;
    check("redir_iaddr0", mem_iaddr, 32'h100);
    tick();
    dp_imemREN = 1'b0;
    #1;
    check("redir_iaddr1", mem_iaddr, 32'h100);
    mem_iwait = 1'b0;
    mem_iload = 32'hAAAA_0100;
    tick();
    mem_iwait = 1'b1;
    expect_hit(32'h100, 32'hAAAA_0100);
    fetch_miss(32'h200, 32'hBBBB_0200, 0);

    // Invalidate in IDLE: three valid frames all miss afterwards
    fetch_miss(32'h0, 32'h0000_1000, 0);
    fetch_miss(32'h4, 32'h0000_1004, 0);
    fetch_miss(32'h8, 32'h0000_1008, 0);
    dp_imemaddr = 32'h0;
    inval = 1'b1;
    #1;
    check("inval_ihit", dp_ihit, 0);
    tick();
    inval = 1'b0;
    #1;
    check("inval_nofetch", mem_iREN, 0);
    fetch_miss(32'h0, 32'h0000_2000, 0);
    fetch_miss(32'h4, 32'h0000_2004, 0);
    fetch_miss(32'h8, 32'h0000_2008, 0);

    // Invalidate coinciding with the fill of 0xC: 0xC misses afterwards
    dp_imemaddr = 32'hC;
    tick();
    inval     = 1'b1;
    mem_iwait = 1'b0;
    mem_iload = 32'h0000_300C;
    tick();
    inval     = 1'b0;
    mem_iwait = 1'b1;
    fetch_miss(32'hC, 32'h0000_400C, 0);

    // Invalidate during FETCH without fill: fill still sets its frame valid,
    // but the older frame of 0x0 is gone
    dp_imemaddr = 32'h10;
    tick();
    inval = 1'b1;
    tick();
    inval     = 1'b0;
    mem_iwait = 1'b0;
    mem_iload = 32'h0000_5010;
    tick();
    mem_iwait = 1'b1;
    expect_hit(32'h10, 32'h0000_5010);
    fetch_miss(32'h0, 32'h0000_6000, 0);

    // Reset during FETCH: request drops immediately, fill is discarded
    dp_imemaddr = 32'h300;
    tick();
    #1;
    check("rstf_iren_before", mem_iREN, 1);
    nRST = 1'b0;
    #1;
    check("rstf_iren_async", mem_iREN, 0);
    check("rstf_iaddr", mem_iaddr, 0);
    tick();
    nRST = 1'b1;
    fetch_miss(32'h300, 32'h0000_7300, 2);
    dp_imemREN = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
